// File: rtl/idma_tilelink_pkg.sv
// ============================================================================
// Module      : idma_tilelink_pkg
// Description : Shared TileLink write-path constants and source-ID helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package idma_tilelink_pkg;

    // Bit positions inside the 2-bit write response {corrupt, denied}
    localparam int unsigned RespDenied  = 0;
    localparam int unsigned RespCorrupt = 1;

    // Width of a source-ID field for a given number of owned sources
    function automatic int unsigned source_width(input int unsigned num_sources);
        return (num_sources > 1) ? $clog2(num_sources) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/idma_tilelink_write_tracker_if.sv
// ============================================================================
// Module      : idma_tilelink_write_tracker_if
// Description : Request, forward, D-channel and response bundle of the tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idma_tilelink_write_tracker_if #(
    parameter int unsigned SourceWidth = 2
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   fwd_valid_o;
    logic                   fwd_ready_i;
    logic [SourceWidth-1:0] fwd_source_o;
    logic                   d_valid_i;
    logic                   d_ready_o;
    logic [SourceWidth-1:0] d_source_i;
    logic                   d_denied_i;
    logic                   d_corrupt_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [1:0]             rsp_resp_o;
    logic                   busy_o;
    logic                   err_o;

    modport slave (
        input  req_valid_i, fwd_ready_i, d_valid_i, d_source_i, d_denied_i,
               d_corrupt_i, rsp_ready_i,
        output req_ready_o, fwd_valid_o, fwd_source_o, d_ready_o, rsp_valid_o,
               rsp_resp_o, busy_o, err_o
    );

    modport master (
        output req_valid_i, fwd_ready_i, d_valid_i, d_source_i, d_denied_i,
               d_corrupt_i, rsp_ready_i,
        input  req_ready_o, fwd_valid_o, fwd_source_o, d_ready_o, rsp_valid_o,
               rsp_resp_o, busy_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/fifo_v3.sv
// ============================================================================
// Module      : fifo_v3
// Description : Register-based FIFO with optional fall-through and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  flush_i,
    output logic                       full_o,
    output logic                       empty_o,
    input  wire logic [DATA_WIDTH-1:0] data_i,
    input  wire logic                  push_i,
    output logic      [DATA_WIDTH-1:0] data_o,
    input  wire logic                  pop_i
);

    localparam logic [ADDR_DEPTH-1:0] c_last = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   c_full = (ADDR_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_rd_ptr, r_wr_ptr;
    logic [ADDR_DEPTH:0]   r_cnt;
    logic                  w_stored_empty, w_bypass, w_do_push, w_do_pop;

    assign w_stored_empty = (r_cnt == '0);
    assign full_o         = (r_cnt == c_full);
    assign empty_o        = w_stored_empty & ~(FALL_THROUGH & push_i);
    assign data_o         = (FALL_THROUGH && w_stored_empty) ? data_i : r_mem[r_rd_ptr];

    // A fall-through push that is popped immediately never touches storage
    assign w_bypass  = FALL_THROUGH & w_stored_empty & push_i & pop_i;
    assign w_do_push = push_i & ~full_o & ~w_bypass;
    assign w_do_pop  = pop_i & ~w_stored_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + (ADDR_DEPTH + 1)'(w_do_push) - (ADDR_DEPTH + 1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/lzc.sv
// ============================================================================
// Module      : lzc
// Description : Leading/trailing zero counter (MODE=0 trailing, MODE=1 leading).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  wire logic [WIDTH-1:0]     in_i,
    output logic      [CNT_WIDTH-1:0] cnt_o,
    output logic                      empty_o
);

    // The scan order makes the last hit the lowest (MODE=0) or highest (MODE=1) set bit
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            int idx;
            idx = MODE ? i : (int'(WIDTH) - 1 - i);
            if (in_i[idx]) begin
                cnt_o = MODE ? CNT_WIDTH'(int'(WIDTH) - 1 - idx) : CNT_WIDTH'(idx);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

`default_nettype wire

// File: rtl/idma_tilelink_write_tracker.sv
// ============================================================================
// Module      : idma_tilelink_write_tracker
// Description : Allocates TileLink source IDs to Put bursts and returns their
//               write responses in issue order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idma_tilelink_write_tracker
    import idma_tilelink_pkg::*;
#(
    parameter int unsigned NumSources  = 4,
    parameter int unsigned SourceWidth = source_width(NumSources)
) (
    input  wire logic                       clk_i,
    input  wire logic                       rst_ni,
    idma_tilelink_write_tracker_if.slave    bus
);

    typedef logic [SourceWidth-1:0] src_t;

    logic [NumSources-1:0] r_free;
    logic [NumSources-1:0] r_done;
    logic [1:0]            r_resp [NumSources];
    logic                  r_err;

    src_t       w_alloc_id, w_head;
    logic       w_no_free, w_fifo_full, w_fifo_empty, w_can_issue;
    logic       w_issue, w_d_legal, w_rsp_valid, w_retire;
    logic [1:0] w_d_resp;

    lzc #(
        .WIDTH (NumSources),
        .MODE  (1'b0)
    ) i_lzc (
        .in_i    (r_free),
        .cnt_o   (w_alloc_id),
        .empty_o (w_no_free)
    );

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (SourceWidth),
        .DEPTH        (NumSources)
    ) i_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .data_i  (w_alloc_id),
        .push_i  (w_issue),
        .data_o  (w_head),
        .pop_i   (w_retire)
    );

    // Allocation only sees the registered free map, so a just-retired ID waits a cycle
    assign w_can_issue      = ~w_no_free & ~w_fifo_full;
    assign bus.fwd_valid_o  = bus.req_valid_i & w_can_issue;
    assign bus.req_ready_o  = bus.fwd_ready_i & w_can_issue;
    assign bus.fwd_source_o = w_alloc_id;
    assign w_issue          = bus.req_valid_i & bus.fwd_ready_i & w_can_issue;

    assign bus.d_ready_o = 1'b1;
    assign w_d_legal     = bus.d_valid_i & ~r_free[bus.d_source_i] & ~r_done[bus.d_source_i];

    always_comb begin
        w_d_resp              = '0;
        w_d_resp[RespDenied]  = bus.d_denied_i;
        w_d_resp[RespCorrupt] = bus.d_corrupt_i;
    end

    assign w_rsp_valid     = ~w_fifo_empty & r_done[w_head];
    assign w_retire        = w_rsp_valid & bus.rsp_ready_i;
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_resp_o  = r_resp[w_head];
    assign bus.busy_o      = ~w_fifo_empty;
    assign bus.err_o       = r_err;

    // Issue, D and retire always target distinct IDs, so their updates never collide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_free <= '1;
            r_done <= '0;
            r_resp <= '{default: '0};
            r_err  <= 1'b0;
        end else begin
            r_err <= bus.d_valid_i & ~w_d_legal;
            if (w_issue) begin
                r_free[w_alloc_id] <= 1'b0;
            end
            if (w_d_legal) begin
                r_done[bus.d_source_i] <= 1'b1;
                r_resp[bus.d_source_i] <= w_d_resp;
            end
            if (w_retire) begin
                r_free[w_head] <= 1'b1;
                r_done[w_head] <= 1'b0;
                r_resp[w_head] <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_idma_tilelink_write_tracker.sv
// ============================================================================
// Module      : tb_idma_tilelink_write_tracker
// Description : Directed self-checking bench for the write tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idma_tilelink_write_tracker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idma_tilelink_write_tracker_if #(.SourceWidth(2)) bus ();

    idma_tilelink_write_tracker #(
        .NumSources  (4),
        .SourceWidth (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [1:0] id_q [$];
    logic [1:0] model_resp [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid_i = 1'b0;
        bus.fwd_ready_i = 1'b0;
        bus.d_valid_i   = 1'b0;
        bus.d_source_i  = '0;
        bus.d_denied_i  = 1'b0;
        bus.d_corrupt_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
    endtask

    // All tasks start and end on a falling edge with inputs idle
    task automatic issue(input logic [1:0] exp_id);
        bus.req_valid_i = 1'b1;
        bus.fwd_ready_i = 1'b1;
        #1;
        chk("issue_fwd_valid", bus.fwd_valid_o, 1);
        chk("issue_req_ready", bus.req_ready_o, 1);
        chk("issue_source", bus.fwd_source_o, exp_id);
        id_q.push_back(exp_id);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.fwd_ready_i = 1'b0;
    endtask

    task automatic d_beat(input logic [1:0] src, input logic corrupt, input logic denied,
                          input logic legal);
        bus.d_valid_i   = 1'b1;
        bus.d_source_i  = src;
        bus.d_corrupt_i = corrupt;
        bus.d_denied_i  = denied;
        if (legal) model_resp[src] = {corrupt, denied};
        @(posedge clk);
        @(negedge clk);
        bus.d_valid_i = 1'b0;
        chk("d_err", bus.err_o, {31'd0, ~legal});
    endtask

    task automatic retire(input int max_wait);
        logic [1:0] id;
        int w = 0;
        while (bus.rsp_valid_o !== 1'b1 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("rsp_valid", bus.rsp_valid_o, 1);
        if (id_q.size() > 0) begin
            id = id_q.pop_front();
            chk("rsp_resp", bus.rsp_resp_o, model_resp[id]);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_d_ready", bus.d_ready_o, 1);
        chk("rst_fwd_source", bus.fwd_source_o, 0);
        chk("rst_fwd_valid_idle", bus.fwd_valid_o, 0);
        bus.req_valid_i = 1'b1;
        #1;
        chk("rst_fwd_valid", bus.fwd_valid_o, 1);
        chk("rst_req_ready_no_fwd", bus.req_ready_o, 0);
        bus.fwd_ready_i = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready_o, 1);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single burst
        issue(2'd0);
        repeat (3) @(negedge clk);
        chk("single_no_rsp", bus.rsp_valid_o, 0);
        chk("single_busy", bus.busy_o, 1);
        d_beat(2'd0, 1'b0, 1'b0, 1'b1);
        chk("single_rsp_next_cycle", bus.rsp_valid_o, 1);
        retire(0);
        chk("single_idle", bus.busy_o, 0);

        // Out-of-order acknowledges, then back-pressure and drain
        for (int i = 0; i < 4; i++) issue(2'(i));
        bus.req_valid_i = 1'b1;
        bus.fwd_ready_i = 1'b1;
        #1;
        chk("full_fwd_valid", bus.fwd_valid_o, 0);
        chk("full_req_ready", bus.req_ready_o, 0);
        bus.req_valid_i = 1'b0;
        bus.fwd_ready_i = 1'b0;
        d_beat(2'd2, 1'b0, 1'b0, 1'b1);
        chk("ooo_head_not_done", bus.rsp_valid_o, 0);
        d_beat(2'd0, 1'b0, 1'b0, 1'b1);
        d_beat(2'd3, 1'b0, 1'b1, 1'b1);
        d_beat(2'd1, 1'b1, 1'b0, 1'b1);
        bus.req_valid_i = 1'b1;
        bus.fwd_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_rsp_valid", bus.rsp_valid_o, 1);
            chk("bp_rsp_resp", bus.rsp_resp_o, model_resp[0]);
            chk("bp_no_issue", bus.req_ready_o, 0);
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0;
        bus.fwd_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) retire(0);
        chk("drain_idle", bus.busy_o, 0);

        // Full stall: fifth request waits for a retire, then reuses source 0
        for (int i = 0; i < 4; i++) issue(2'(i));
        bus.req_valid_i = 1'b1;
        bus.fwd_ready_i = 1'b1;
        #1;
        chk("stall_req_ready", bus.req_ready_o, 0);
        d_beat(2'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_done_not_free", bus.req_ready_o, 0);
        retire(0);
        bus.req_valid_i = 1'b1;
        bus.fwd_ready_i = 1'b1;
        issue(2'd0);
        d_beat(2'd1, 1'b0, 1'b1, 1'b1);
        d_beat(2'd2, 1'b1, 1'b1, 1'b1);
        d_beat(2'd3, 1'b0, 1'b0, 1'b1);
        d_beat(2'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) retire(0);
        chk("stall_drain_idle", bus.busy_o, 0);

        // Spurious and duplicate D beats
        issue(2'd0);
        d_beat(2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("spur_err_one_pulse", bus.err_o, 0);
        chk("spur_no_rsp", bus.rsp_valid_o, 0);
        chk("spur_next_alloc", bus.fwd_source_o, 1);
        d_beat(2'd0, 1'b0, 1'b1, 1'b1);
        retire(0);
        d_beat(2'd0, 1'b0, 1'b0, 1'b0);
        chk("dup_no_rsp", bus.rsp_valid_o, 0);
        chk("dup_idle", bus.busy_o, 0);
        chk("dup_alloc", bus.fwd_source_o, 0);

        // Reset mid-flight
        issue(2'd0);
        issue(2'd1);
        issue(2'd2);
        d_beat(2'd1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
        rst_n = 1'b1;
        id_q.delete();
        @(negedge clk);
        chk("post_rst_busy", bus.busy_o, 0);
        d_beat(2'd1, 1'b0, 1'b0, 1'b0);
        issue(2'd0);
        d_beat(2'd0, 1'b0, 1'b0, 1'b1);
        retire(0);
        chk("final_idle", bus.busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
